minirisc_prog_feeder: RTL and testbench
=======================================

// Module: minirisc_prog_feeder
// PURPOSE
// - Hardware program source for tt_um_minirisc: buffers (opcode, operand) byte pairs from a host and issues them to the core.
// - Opcode drives the core's ui_in; operand drives its uio_in. Replaces bench-driven stimulus with an on-chip, handshaked stream.
// - Sits between the host/loader interface and the core input pins; one pair issued per accepted handshake.
// PARAMETERS
// - DEPTH  16  program entries held (power of two, >= 2)
// - DW     8   width of opcode and of operand
// PORTS
// - clk          in   1          system clock, rising edge
// - rst_n        in   1          reset, synchronous, active-low
// - ena          in   1          global enable; 0 freezes all state (no loads, no issues)
// - clear        in   1          flush buffer, return to IDLE
// - load_valid   in   1          host offers a pair
// - load_opc     in   DW         opcode to store
// - load_opr     in   DW         operand to store
// - load_ready   out  1          1 only in IDLE with count < DEPTH
// - start        in   1          begin issuing (sampled in IDLE)
// - core_ready   in   1          core accepts the presented pair this cycle
// - core_valid   out  1          core_opc/core_opr hold a valid pair
// - core_opc     out  DW         opcode to core ui_in
// - core_opr     out  DW         operand to core uio_in
// - busy         out  1          1 in RUN
// - done         out  1          one-cycle pulse on leaving RUN
// - err_empty    out  1          sticky: start seen with count == 0; cleared by clear or reset
// - count        out  $clog2(DEPTH)+1  entries currently stored
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state IDLE, pointers 0, count 0; all outputs 0 except load_ready=1.
// - States: IDLE, RUN, DONE. DONE lasts exactly one cycle (done=1), then IDLE.
// - IDLE: load_valid&&load_ready writes pair at wr_ptr, wr_ptr++, count++. Full (count==DEPTH): load_ready=0, pair dropped by host protocol.
// - IDLE + start: count>0 -> RUN next cycle; count==0 -> stay IDLE, set err_empty.
// - Same-cycle load and start in IDLE: load accepted; new entry is part of the run.
// - RUN: core_valid=1 from first RUN cycle, presenting entry rd_ptr; outputs registered, stable while core_ready=0.
// - Transfer = core_valid && core_ready. On transfer rd_ptr++; next entry presented the following cycle (1 pair/cycle max).
// - RUN -> DONE on transfer of opcode 8'h00 (HALT) or of the last stored entry; HALT itself is issued.
// - DONE/IDLE: core_valid=0, core_opc=core_opr=0. Loads blocked in RUN and DONE (load_ready=0).
// - Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
// - clear: highest priority after reset; any state -> IDLE, pointers/count/err_empty to 0, core_valid drops next cycle, no done pulse.
// - ena=0: all registers hold; core_valid keeps its value but no transfer counts.
// - Reset mid-RUN: identical to reset; partial program discarded.
// CONFIGURATION
// - PROG_REPLAY_EN undefined: buffer is a FIFO; issued entries are consumed; on DONE remaining entries (after HALT) discarded, count=0.
// - PROG_REPLAY_EN defined: buffer is program memory; entries retained; on DONE rd_ptr rewinds to 0, count unchanged,
//   next start replays from entry 0; IDLE loads append; only clear/reset empty it.
// STRUCTURE
// - Package minirisc_pkg: DW, OPC_HALT=8'h00, feeder state enum {IDLE,RUN,DONE}.
// - Sub-module prog_buf_ram: DEPTH x (2*DW) register array, 1 write port, 1 async read port; control FSM in this module.
// TESTING
// - Reset: hold rst_n=0 two cycles -> core_valid=0, count=0, load_ready=1, done=0, err_empty=0.
// - Load (01,01),(02,02),(03,03),(00,00); start; core_ready=1 -> core_opc 01,02,03,00 on 4 consecutive cycles, done pulse, count=0.
// - Backpressure: same program, core_ready=0 for 3 cycles mid-run -> core_opc held at 02, no skip or duplicate.
// - Full: 16 loads then 17th load_valid -> load_ready=0 at count=16; run issues 16 pairs, done after 16th (no HALT).
// - start with count=0 -> stays IDLE, err_empty=1; clear -> err_empty=0. clear mid-RUN -> IDLE, count=0, no done.
// - PROG_REPLAY_EN: load (05,0A),(00,00); run twice -> both runs issue 05 then 00; count=2 after each run.

Source files
------------

// File: rtl/minirisc_pkg.sv
// Shared constants and state encoding for the minirisc program feeder.
package minirisc_pkg;

  localparam int DW = 8;
  localparam logic [7:0] OPC_HALT = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/prog_buf_ram.sv
// Program buffer storage: register array with one synchronous write port and one async read port.
module prog_buf_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/minirisc_prog_feeder.sv
// Buffers (opcode, operand) pairs from a host and issues them to tt_um_minirisc over a valid/ready stream.
// Define PROG_REPLAY_EN to keep the program after a run and replay it from entry 0 on every start.
module minirisc_prog_feeder
  import minirisc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = minirisc_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   clear,
  input  logic                   load_valid,
  input  logic [DW-1:0]          load_opc,
  input  logic [DW-1:0]          load_opr,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   core_ready,
  output logic                   core_valid,
  output logic [DW-1:0]          core_opc,
  output logic [DW-1:0]          core_opr,
  output logic                   busy,
  output logic                   done,
  output logic                   err_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  feeder_state_t   state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            err_reg, err_next;
  logic            cv_reg, cv_next;
  logic [DW-1:0]   opc_reg, opc_next;
  logic [DW-1:0]   opr_reg, opr_next;

  logic            load_fire;
  logic            xfer;
  logic            last;
  logic [AW-1:0]   raddr;
  logic [2*DW-1:0] rdata;

  assign load_ready = (state_reg == IDLE) && (count_reg < CW'(DEPTH));
  assign load_fire  = ena && !clear && load_valid && load_ready;
  assign xfer       = (state_reg == RUN) && cv_reg && core_ready;

  // In RUN the next entry is prefetched so it can be registered on the transfer edge.
  assign raddr = (state_reg == RUN) ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  prog_buf_ram #(
    .DEPTH (DEPTH),
    .W     (2*DW)
  ) u_buf (
    .clk   (clk),
    .we    (load_fire),
    .waddr (wr_ptr_reg),
    .wdata ({load_opc, load_opr}),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef PROG_REPLAY_EN
  assign last = (opc_reg == DW'(OPC_HALT)) || ({1'b0, rd_ptr_reg} + CW'(1) == count_reg);
`else
  assign last = (opc_reg == DW'(OPC_HALT)) || (count_reg == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
      cv_reg     <= 1'b0;
      opc_reg    <= '0;
      opr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
      cv_reg     <= cv_next;
      opc_reg    <= opc_next;
      opr_reg    <= opr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    cv_next     = cv_reg;
    opc_next    = opc_reg;
    opr_next    = opr_reg;

    if (clear) begin
      state_next  = IDLE;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      err_next    = 1'b0;
      cv_next     = 1'b0;
      opc_next    = '0;
      opr_next    = '0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (load_fire) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
            count_next  = count_reg + CW'(1);
          end
          if (start) begin
            if (count_reg != '0 || load_fire) begin
              state_next = RUN;
              cv_next    = 1'b1;
              // A pair written this same cycle may be the first one to issue.
              if (load_fire && wr_ptr_reg == rd_ptr_reg) begin
                opc_next = load_opc;
                opr_next = load_opr;
              end else begin
                opc_next = rdata[2*DW-1:DW];
                opr_next = rdata[DW-1:0];
              end
            end else begin
              err_next = 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              state_next  = DONE;
              cv_next     = 1'b0;
              opc_next    = '0;
              opr_next    = '0;
              rd_ptr_next = '0;
`ifndef PROG_REPLAY_EN
              wr_ptr_next = '0;
              count_next  = '0;
`endif
            end else begin
              rd_ptr_next = rd_ptr_reg + AW'(1);
              opc_next    = rdata[2*DW-1:DW];
              opr_next    = rdata[DW-1:0];
`ifndef PROG_REPLAY_EN
              count_next  = count_reg - CW'(1);
`endif
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign core_valid = cv_reg;
  assign core_opc   = opc_reg;
  assign core_opr   = opr_reg;
  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign err_empty  = err_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_minirisc_prog_feeder.sv
// Self-checking bench for minirisc_prog_feeder: loaded pairs go to a program queue, issued pairs are checked against it.
module tb_minirisc_prog_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic       load_valid;
  logic [7:0] load_opc;
  logic [7:0] load_opr;
  logic       load_ready;
  logic       start;
  logic       core_ready;
  logic       core_valid;
  logic [7:0] core_opc;
  logic [7:0] core_opr;
  logic       busy;
  logic       done;
  logic       err_empty;
  logic [4:0] count;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [15:0] prog[$];
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  minirisc_prog_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .load_valid (load_valid),
    .load_opc   (load_opc),
    .load_opr   (load_opr),
    .load_ready (load_ready),
    .start      (start),
    .core_ready (core_ready),
    .core_valid (core_valid),
    .core_opc   (core_opc),
    .core_opr   (core_opr),
    .busy       (busy),
    .done       (done),
    .err_empty  (err_empty),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    check("flush_count", 32'(count), 0);
  endtask

  task automatic load_pair(input logic [7:0] o, input logic [7:0] r);
    logic exp_rdy;
    exp_rdy    = (prog.size() < 16);
    load_valid = 1'b1;
    load_opc   = o;
    load_opr   = r;
    check("load_ready", 32'(load_ready), 32'(exp_rdy));
    tick();
    load_valid = 1'b0;
    if (exp_rdy) prog.push_back({o, r});
    $display("load opc=%02h opr=%02h accepted=%0d count=%0d", o, r, exp_rdy, count);
    check("count_load", 32'(count), prog.size());
  endtask

  // Issues the buffered program; holds off for stall_len cycles before transfer number stall_at,
  // either by dropping core_ready or by dropping ena with core_ready high.
  task automatic run_prog(input int stall_at, input int stall_len, input bit use_ena);
    int issued = 0;
    int cycles = 0;
    int stall_left = stall_len;
    bit fin = 0;
    logic [15:0] exp;
    sb = prog;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 1);
    while (!fin && cycles < 200) begin
      cycles++;
      check("core_valid", 32'(core_valid), 1);
      check("core_opc", 32'(core_opc), 32'(sb[0][15:8]));
      check("core_opr", 32'(core_opr), 32'(sb[0][7:0]));
`ifndef PROG_REPLAY_EN
      check("count_run", 32'(count), sb.size());
`endif
      if (issued == stall_at && stall_left > 0) begin
        stall_left--;
        if (use_ena) begin
          ena = 1'b0;
          core_ready = 1'b1;
        end else begin
          core_ready = 1'b0;
        end
        tick();
        continue;
      end
      ena = 1'b1;
      core_ready = 1'b1;
      exp = sb.pop_front();
      tick();
      issued++;
      $display("issue opc=%02h opr=%02h", exp[15:8], exp[7:0]);
      if (exp[15:8] == 8'h00 || sb.size() == 0) fin = 1;
    end
    core_ready = 1'b0;
    ena = 1'b1;
    check("run_finished", 32'(fin), 1);
    check("run_cycles", cycles, issued + stall_len);
    check("done_pulse", 32'(done), 1);
    check("done_valid", 32'(core_valid), 0);
    check("done_opc", 32'(core_opc), 0);
    check("done_busy", 32'(busy), 0);
`ifndef PROG_REPLAY_EN
    prog.delete();
`endif
    check("count_end", 32'(count), prog.size());
    tick();
    check("done_drop", 32'(done), 0);
    check("ready_after", 32'(load_ready), 32'(prog.size() < 16));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; load_valid = 1'b0;
    load_opc = '0; load_opr = '0; start = 1'b0; core_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(core_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(load_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_empty), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Basic program, no backpressure.
    load_pair(8'h01, 8'h01); load_pair(8'h02, 8'h02);
    load_pair(8'h03, 8'h03); load_pair(8'h00, 8'h00);
    run_prog(-1, 0, 0);

    // Backpressure after the first transfer: 02 must be held for 3 cycles.
    flush();
    load_pair(8'h01, 8'h01); load_pair(8'h02, 8'h02);
    load_pair(8'h03, 8'h03); load_pair(8'h00, 8'h00);
    run_prog(1, 3, 0);

    // ena low freezes the presented pair even with core_ready high.
    flush();
    load_pair(8'h11, 8'h21); load_pair(8'h12, 8'h22); load_pair(8'h13, 8'h23);
    run_prog(2, 2, 1);

    // Full buffer: 17th offer refused, all 16 issued without HALT.
    flush();
    for (int i = 0; i < 17; i++)
      load_pair(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)));
    check("full_ready", 32'(load_ready), 0);
    run_prog(5, 1, 0);

    // HALT mid-program: HALT issued, trailing entries discarded.
    flush();
    load_pair(8'h07, 8'h70); load_pair(8'h00, 8'h5A); load_pair(8'h09, 8'h90);
    run_prog(-1, 0, 0);

    // start on empty buffer.
    flush();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_busy", 32'(busy), 0);
    check("empty_err", 32'(err_empty), 1);
    check("empty_valid", 32'(core_valid), 0);
    flush();
    check("err_cleared", 32'(err_empty), 0);

    // clear mid-RUN.
    load_pair(8'h31, 8'h41); load_pair(8'h32, 8'h42); load_pair(8'h33, 8'h43);
    start = 1'b1;
    tick();
    start = 1'b0;
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    check("mid_opc", 32'(core_opc), 32'h32);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    check("clr_busy", 32'(busy), 0);
    check("clr_valid", 32'(core_valid), 0);
    check("clr_count", 32'(count), 0);
    check("clr_done", 32'(done), 0);
    tick();
    check("clr_done2", 32'(done), 0);

    // Reset mid-RUN.
    load_pair(8'h51, 8'h61); load_pair(8'h52, 8'h62);
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prog.delete();
    check("rrst_valid", 32'(core_valid), 0);
    check("rrst_count", 32'(count), 0);
    check("rrst_ready", 32'(load_ready), 1);

`ifdef PROG_REPLAY_EN
    // Program retained and replayed from entry 0.
    flush();
    load_pair(8'h05, 8'h0A); load_pair(8'h00, 8'h00);
    run_prog(-1, 0, 0);
    run_prog(-1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
